sram_boot_loader: RTL and testbench



---
 rtl/sram_boot_loader_pkg.sv | 37 +++
 rtl/sram_boot_word_packer.sv | 39 +++
 rtl/sram_boot_loader.sv | 117 +++++++++++
 tb/tb_sram_boot_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_boot_loader_pkg.sv
// Shared types and constants for the SRAM firmware boot loader.
// The loader turns a length-prefixed, checksummed byte stream into SRAM word writes.
package sram_boot_loader_pkg;

  localparam int DEPTH          = 512;
  localparam int ADDR_W         = $clog2(DEPTH);
  localparam int CNT_W          = ADDR_W + 1;
  localparam int WORD_W         = 45;
  localparam int BYTES_PER_WORD = 6;
  localparam int IDX_W          = 3;
  localparam int COLS           = 4;
  localparam int COL_W          = $clog2(COLS);
  localparam int ROW_W          = ADDR_W - COL_W;

  // The top byte of a word only partly lands in the word; the rest is discarded.
  localparam int LAST_BITS = WORD_W - 8 * (BYTES_PER_WORD - 1);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [1:0] err_cause;
  } loader_dbg_t;

endpackage

// File: rtl/sram_boot_word_packer.sv
// Assembles payload bytes little-endian into one SRAM word and pulses word_valid
// the cycle after the final byte of a word is taken.
module sram_boot_word_packer
  import sram_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [IDX_W-1:0] byte_idx_q;

  assign last_byte = (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1));

  // Gaps in byte_valid simply hold the index and the partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx_q <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= byte_valid && last_byte;
      if (byte_valid) begin
        if (last_byte) begin
          byte_idx_q                           <= '0;
          word_data[WORD_W-1 -: LAST_BITS]     <= byte_data[LAST_BITS-1:0];
        end else begin
          byte_idx_q                           <= byte_idx_q + IDX_W'(1);
          word_data[byte_idx_q * 8 +: 8]       <= byte_data;
        end
      end
    end
  end

endmodule

// File: rtl/sram_boot_loader.sv
// Firmware loader: parses LEN_LO, LEN_HI, payload and XOR checksum from a byte stream,
// writes words to SRAM in address order, and holds the CPU in reset until the image checks out.
module sram_boot_loader
  import sram_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  // Byte stream: a byte moves on a rising clk where s_valid and s_ready are both high;
  // s_valid may drop at any time, and s_ready never depends on s_valid.
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              sram_we,
  output logic [ROW_W-1:0]  sram_row,
  output logic [COL_W-1:0]  sram_col,
  output logic [WORD_W-1:0] sram_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded,
  output loader_dbg_t       dbg
);

  state_t           state_q, state_d;
  logic [1:0]       err_q, err_d;
  logic [15:0]      len_q;
  logic [7:0]       csum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s_ready_q;
  logic             accept;
  logic             pay_accept;
  logic             last_byte;
  logic             word_valid;
  logic [15:0]      len_full;
  logic             last_word;

  assign accept     = s_valid && s_ready_q;
  assign pay_accept = accept && (state_q == ST_PAYLOAD);
  assign len_full   = {s_data, len_q[7:0]};
  assign last_word  = (16'(cnt_q) + 16'd1) == len_q;

  sram_boot_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (pay_accept),
    .byte_data  (s_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word_data  (sram_wdata)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_LEN_LO:  if (accept) state_d = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if (len_full == 16'd0 || len_full > 16'(DEPTH)) begin
            state_d = ST_ERR;
            err_d   = ERR_LEN;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: if (accept && last_byte) state_d = ST_WRITE;
      ST_WRITE:   state_d = last_word ? ST_CHECK : ST_PAYLOAD;
      ST_CHECK: begin
        if (accept) begin
          if (s_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_CSUM;
          end
        end
      end
      ST_DONE:    state_d = ST_DONE;
      ST_ERR:     state_d = ST_ERR;
      default:    state_d = ST_ERR;
    endcase
  end

  // s_ready is registered from the next state so it is low throughout reset
  // and rises on the first clock after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_LEN_LO;
      err_q     <= ERR_NONE;
      len_q     <= '0;
      csum_q    <= '0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      s_ready_q <= state_d inside {ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD, ST_CHECK};
      if (accept && state_q == ST_LEN_LO) len_q[7:0]  <= s_data;
      if (accept && state_q == ST_LEN_HI) len_q[15:8] <= s_data;
      if (pay_accept) csum_q <= csum_q ^ s_data;
      if (state_q == ST_WRITE) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The write address is the count before this cycle's increment.
  assign s_ready      = s_ready_q;
  assign sram_we      = word_valid;
  assign sram_row     = cnt_q[ADDR_W-1:COL_W];
  assign sram_col     = cnt_q[COL_W-1:0];
  assign cpu_hold     = (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);
  assign words_loaded = cnt_q;
  assign dbg          = '{state: state_q, err_cause: err_q};

endmodule

// File: tb/tb_sram_boot_loader.sv
// Directed bench for sram_boot_loader: drives images byte by byte and scoreboards
// every SRAM write against an expected queue filled as words are sent.
module tb_sram_boot_loader;
  import sram_boot_loader_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [7:0]        s_data = 8'h00;
  logic              sram_we;
  logic [ROW_W-1:0]  sram_row;
  logic [COL_W-1:0]  sram_col;
  logic [WORD_W-1:0] sram_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  words_loaded;
  loader_dbg_t       dbg;

  // clock / reset
  always #5 clk = ~clk;

  sram_boot_loader dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .sram_we      (sram_we),
    .sram_row     (sram_row),
    .sram_col     (sram_col),
    .sram_wdata   (sram_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .dbg          (dbg)
  );

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          wr_cnt = 0;
  logic [53:0] exp_q[$];
  logic [53:0] last_wr = '0;
  logic [9:0]  exp_addr = '0;
  logic [7:0]  csum = 8'h00;
  bit          gaps = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // scoreboard: every write strobe must match the next expected {row, col, data}
  always @(negedge clk) begin
    if (sram_we === 1'b1) begin
      wr_cnt++;
      last_wr = {sram_row, sram_col, sram_wdata};
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $error("FAIL unexpected_write: observed row %0d col %0d data 0x%0h, expected no write",
               sram_row, sram_col, sram_wdata);
      end else begin
        check("sram_write", {sram_row, sram_col, sram_wdata}, exp_q.pop_front());
      end
    end
  end

  // drivers (all called at a negedge)
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    while (gaps && $urandom_range(0, 1) == 0) @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (s_ready !== 1'b1) begin
      chk_cnt++;
      $error("FAIL handshake_timeout: s_ready observed %b expected 1", s_ready);
    end else begin
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [47:0] w);
    exp_q.push_back({exp_addr[8:2], exp_addr[1:0], w[44:0]});
    exp_addr = exp_addr + 10'd1;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      csum = csum ^ w[8*k +: 8];
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic send_csum(input logic [7:0] flip);
    send_byte(csum ^ flip);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_addr = '0;
    csum     = 8'h00;
    wr_cnt   = 0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset values while reset is held
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_sram_we", sram_we, 1'b0);
    check("rst_sram_row", sram_row, '0);
    check("rst_sram_col", sram_col, '0);
    check("rst_sram_wdata", sram_wdata, '0);
    check("rst_cpu_hold", cpu_hold, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_words_loaded", words_loaded, '0);
    check("rst_state", dbg.state, ST_LEN_LO);
    reset = 1'b0;
    @(negedge clk);
    check("s_ready_after_reset", s_ready, 1'b1);

    // single word image
    send_len(16'd1);
    send_word(48'h1F0504030201);
    check("t1_we_after_6th", sram_we, 1'b1);
    check("t1_ready_in_write", s_ready, 1'b0);
    @(negedge clk);
    check("t1_ready_after_write", s_ready, 1'b1);
    send_csum(8'h00);
    check("t1_done", done, 1'b1);
    check("t1_cpu_hold", cpu_hold, 1'b0);
    check("t1_error", error, 1'b0);
    check("t1_words_loaded", words_loaded, 10'd1);
    check("t1_writes", wr_cnt, 1);

    // full-depth image, word i = i
    do_reset();
    send_len(16'd512);
    for (int i = 0; i < 512; i++) send_word(48'(i));
    send_csum(8'h00);
    check("t2_done", done, 1'b1);
    check("t2_words_loaded", words_loaded, 10'd512);
    check("t2_writes", wr_cnt, 512);
    check("t2_last_write", last_wr, {7'd127, 2'd3, 45'h1FF});

    // bad checksum; top byte bits above the word are discarded
    do_reset();
    send_len(16'd2);
    send_word(48'hFFA1B2C3D4E5);
    send_word(48'h123456789ABC);
    send_csum(8'h01);
    check("t3_error", error, 1'b1);
    check("t3_done", done, 1'b0);
    check("t3_cpu_hold", cpu_hold, 1'b1);
    check("t3_err_cause", dbg.err_cause, ERR_CSUM);
    check("t3_writes", wr_cnt, 2);
    @(negedge clk);
    check("t3_ready_after_err", s_ready, 1'b0);

    // zero length
    do_reset();
    send_len(16'h0000);
    check("t4a_error", error, 1'b1);
    check("t4a_err_cause", dbg.err_cause, ERR_LEN);
    check("t4a_ready", s_ready, 1'b0);
    repeat (4) @(negedge clk);
    check("t4a_writes", wr_cnt, 0);

    // one word too many
    do_reset();
    send_len(16'h0201);
    check("t4b_error", error, 1'b1);
    check("t4b_cpu_hold", cpu_hold, 1'b1);
    repeat (4) @(negedge clk);
    check("t4b_writes", wr_cnt, 0);

    // random valid gaps
    do_reset();
    gaps = 1'b1;
    send_len(16'd4);
    for (int i = 0; i < 4; i++) send_word({16'($urandom), $urandom});
    send_csum(8'h00);
    gaps = 1'b0;
    check("t5_done", done, 1'b1);
    check("t5_words_loaded", words_loaded, 10'd4);
    check("t5_writes", wr_cnt, 4);

    // reset part way through the third word, then a fresh two-word image
    do_reset();
    send_len(16'd4);
    send_word(48'h0000_1111_2222);
    send_word(48'h3333_4444_5555);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #3 reset = 1'b1;
    #1;
    check("t6_rst_words_loaded", words_loaded, '0);
    check("t6_rst_cpu_hold", cpu_hold, 1'b1);
    check("t6_rst_s_ready", s_ready, 1'b0);
    check("t6_rst_state", dbg.state, ST_LEN_LO);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_addr = '0;
    csum     = 8'h00;
    wr_cnt   = 0;
    @(negedge clk);
    send_len(16'd2);
    send_word(48'h0ABC_DEF0_1234);
    send_word(48'hFEDC_BA98_7654);
    send_csum(8'h00);
    check("t6_done", done, 1'b1);
    check("t6_words_loaded", words_loaded, 10'd2);
    check("t6_writes", wr_cnt, 2);
    check("t6_exp_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
